// File: rtl/cpu_pkg.sv
// Shared CPU definitions used by the data-memory / writeback controller.
package cpu_pkg;

  // Controller sequencing states, 2-bit encoding.
  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_WAIT = 2'd1,
    S_ERR  = 2'd2
  } state_e;

  // Architectural zero register: writes to it are suppressed.
  localparam logic [4:0] REG_ZERO = 5'd0;

endpackage

// File: rtl/load_wb_ctrl.sv
// Load/store sequencer and registered writeback stage.
// Turns decoded memory instructions into a req/ack transaction on a
// variable-latency data memory, stalls the core while it is outstanding,
// and drives a one-cycle writeback pulse into the register file.
module load_wb_ctrl
  import cpu_pkg::*;
#(
  parameter int TIMEOUT = 16,
  parameter int CNT_W   = 8
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        instr_valid,
  input  logic        mem_read,
  input  logic        mem_write,
  input  logic        reg_write,
  input  logic [4:0]  rd,
  input  logic [31:0] alu_data,
  input  logic [31:0] store_data,
  output logic        mem_req,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  input  logic [31:0] mem_rdata,
  input  logic        mem_ack,
  output logic        stall,
  output logic        wb_en,
  output logic [4:0]  wb_rd,
  output logic [31:0] wb_data,
  output logic        m2reg,
  output logic        bus_err
);

  // Last counter value before the timeout fires.
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  // Transaction context captured when a memory instruction is accepted.
  logic [4:0] rd_q;
  logic       ld_q;
  logic       rw_q;
  logic       we_q;

  logic accept;  // memory instruction accepted this cycle
  logic wb_alu;  // ALU result writes back next cycle
  logic wb_mem;  // load data writes back next cycle

  // Request/error flags come straight from the registered state so an
  // asynchronous reset drops them without waiting for a clock.
  assign mem_req = (state_q == S_WAIT);
  assign mem_we  = mem_req & we_q;
  assign bus_err = (state_q == S_ERR);

  // State and timeout counter register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // Next-state, counter, stall and writeback-trigger decode.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    accept  = 1'b0;
    wb_alu  = 1'b0;
    wb_mem  = 1'b0;
    stall   = 1'b0;
    case (state_q)
      S_IDLE: begin
        stall = instr_valid & (mem_read | mem_write);
        if (instr_valid) begin
          if (mem_read && mem_write) begin
            state_d = S_ERR;
          end else if (mem_read || mem_write) begin
            accept  = 1'b1;
            cnt_d   = '0;
            state_d = S_WAIT;
          end else if (reg_write) begin
            wb_alu = 1'b1;
          end
        end
      end
      S_WAIT: begin
        stall = ~mem_ack;
        // An ack in the final timeout cycle still completes normally.
        if (mem_ack) begin
          wb_mem  = ld_q & rw_q;
          cnt_d   = '0;
          state_d = S_IDLE;
        end else if (cnt_q == CNT_LAST) begin
          state_d = S_ERR;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      S_ERR: begin
        stall = 1'b1;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // Capture address, store data and instruction context on accept; they
  // stay stable for the whole time mem_req is high.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mem_addr  <= '0;
      mem_wdata <= '0;
      rd_q      <= '0;
      ld_q      <= 1'b0;
      rw_q      <= 1'b0;
      we_q      <= 1'b0;
    end else if (accept) begin
      mem_addr  <= alu_data;
      mem_wdata <= store_data;
      rd_q      <= rd;
      ld_q      <= mem_read;
      rw_q      <= reg_write;
      we_q      <= mem_write;
    end
  end

  // Registered writeback stage: wb_en is a single-cycle pulse; index, data
  // and source select hold their last value between writebacks.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wb_en   <= 1'b0;
      wb_rd   <= '0;
      wb_data <= '0;
      m2reg   <= 1'b0;
    end else begin
      wb_en <= 1'b0;
      if (wb_alu) begin
        wb_en   <= (rd != REG_ZERO);
        wb_rd   <= rd;
        wb_data <= alu_data;
        m2reg   <= 1'b0;
      end else if (wb_mem) begin
        wb_en   <= (rd_q != REG_ZERO);
        wb_rd   <= rd_q;
        wb_data <= mem_rdata;
        m2reg   <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_load_wb_ctrl.sv
// Self-checking bench for load_wb_ctrl: directed vector table, multi-cycle
// corner sequences, and random traffic against a transaction-level model.
module tb_load_wb_ctrl;

  localparam int TO = 4;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        instr_valid = 1'b0, mem_read = 1'b0, mem_write = 1'b0, reg_write = 1'b0;
  logic [4:0]  rd = '0;
  logic [31:0] alu_data = '0, store_data = '0, mem_rdata = '0;
  logic        mem_ack = 1'b0;
  logic        mem_req, mem_we, stall, wb_en, m2reg, bus_err;
  logic [31:0] mem_addr, mem_wdata, wb_data;
  logic [4:0]  wb_rd;

  int nchk = 0;
  int nerr = 0;

  load_wb_ctrl #(.TIMEOUT(TO), .CNT_W(8)) dut (
    .clk(clk), .rst_n(rst_n), .instr_valid(instr_valid), .mem_read(mem_read),
    .mem_write(mem_write), .reg_write(reg_write), .rd(rd), .alu_data(alu_data),
    .store_data(store_data), .mem_req(mem_req), .mem_we(mem_we),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
    .mem_ack(mem_ack), .stall(stall), .wb_en(wb_en), .wb_rd(wb_rd),
    .wb_data(wb_data), .m2reg(m2reg), .bus_err(bus_err)
  );

  always #5 clk = ~clk;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    nchk++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic drive(input logic iv, input logic r, input logic w, input logic rw,
                       input logic [4:0] rdi, input logic [31:0] alu, input logic [31:0] sd,
                       input logic ack, input logic [31:0] rdat);
    instr_valid = iv; mem_read = r; mem_write = w; reg_write = rw;
    rd = rdi; alu_data = alu; store_data = sd; mem_ack = ack; mem_rdata = rdat;
  endtask

  // One cycle: apply inputs just after the falling edge, settle, then checks follow.
  task automatic cyc(input logic iv, input logic r, input logic w, input logic rw,
                     input logic [4:0] rdi, input logic [31:0] alu, input logic [31:0] sd,
                     input logic ack, input logic [31:0] rdat);
    @(negedge clk);
    drive(iv, r, w, rw, rdi, alu, sd, ack, rdat);
    #1;
  endtask

  task automatic idle(input logic ack);
    cyc(0, 0, 0, 0, 5'd0, 32'h0, 32'h0, ack, 32'h0);
  endtask

  task automatic do_reset();
    @(negedge clk);
    drive(0, 0, 0, 0, 5'd0, 32'h0, 32'h0, 0, 32'h0);
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
  endtask

  // ---------------- directed vector table ----------------
  typedef struct {
    logic iv, r, w, rw; logic [4:0] rdi; logic [31:0] alu, sd; logic ack; logic [31:0] rdat;
    logic st, rq, we; logic [31:0] a, wd; logic wbe; logic [4:0] wbr; logic [31:0] wbd;
    logic m2, er;
  } vec_t;

  function automatic vec_t v(logic iv, logic r, logic w, logic rw, logic [4:0] rdi,
      logic [31:0] alu, logic [31:0] sd, logic ack, logic [31:0] rdat,
      logic st, logic rq, logic we, logic [31:0] a, logic [31:0] wd,
      logic wbe, logic [4:0] wbr, logic [31:0] wbd, logic m2, logic er);
    vec_t x;
    x.iv = iv; x.r = r; x.w = w; x.rw = rw; x.rdi = rdi; x.alu = alu; x.sd = sd;
    x.ack = ack; x.rdat = rdat; x.st = st; x.rq = rq; x.we = we; x.a = a; x.wd = wd;
    x.wbe = wbe; x.wbr = wbr; x.wbd = wbd; x.m2 = m2; x.er = er;
    return x;
  endfunction

  vec_t tbl[$];

  // ---------------- reference model ----------------
  // Tracks "is a memory access outstanding", how long it has waited, and
  // what the register file should see, from the behavioural rules only.
  bit          m_err, m_busy;
  int          m_waited;
  logic [4:0]  p_rd;
  bit          p_load, p_rw, p_store;
  logic [31:0] x_addr, x_wdata, x_wbd;
  logic [4:0]  x_wbr;
  bit          x_wbe, x_m2;

  task automatic model_reset();
    m_err = 0; m_busy = 0; m_waited = 0; p_rd = 0; p_load = 0; p_rw = 0; p_store = 0;
    x_addr = 0; x_wdata = 0; x_wbd = 0; x_wbr = 0; x_wbe = 0; x_m2 = 0;
  endtask

  task automatic model_check();
    bit want_stall;
    if (m_err)       want_stall = 1;
    else if (m_busy) want_stall = !mem_ack;
    else             want_stall = instr_valid && (mem_read || mem_write);
    check("rnd_stall", stall, want_stall);
    check("rnd_req", mem_req, m_busy);
    check("rnd_we", mem_we, m_busy && p_store);
    check("rnd_addr", mem_addr, x_addr);
    check("rnd_wdata", mem_wdata, x_wdata);
    check("rnd_wben", wb_en, x_wbe);
    check("rnd_wbrd", wb_rd, x_wbr);
    check("rnd_wbdata", wb_data, x_wbd);
    check("rnd_m2reg", m2reg, x_m2);
    check("rnd_buserr", bus_err, m_err);
  endtask

  task automatic model_clock();
    x_wbe = 0;
    if (m_err) return;
    if (m_busy) begin
      if (mem_ack) begin
        m_busy = 0;
        if (p_load && p_rw) begin
          x_wbe = (p_rd != 0); x_wbr = p_rd; x_wbd = mem_rdata; x_m2 = 1;
        end
      end else begin
        m_waited++;
        if (m_waited == TO) begin m_busy = 0; m_err = 1; end
      end
    end else if (instr_valid) begin
      if (mem_read && mem_write) m_err = 1;
      else if (mem_read || mem_write) begin
        m_busy = 1; m_waited = 0; p_rd = rd; p_load = mem_read; p_rw = reg_write;
        p_store = mem_write; x_addr = alu_data; x_wdata = store_data;
      end else if (reg_write) begin
        x_wbe = (rd != 0); x_wbr = rd; x_wbd = alu_data; x_m2 = 0;
      end
    end
  endtask

  initial begin
    int err_age;
    // cycle-by-cycle: inputs of a cycle and outputs observed in that cycle
    tbl.push_back(v(0,0,0,0,0,0,0,0,0,                    0,0,0,0,0,0,0,0,0,0));
    tbl.push_back(v(1,0,0,1,3,32'hAA,0,0,0,               0,0,0,0,0,0,0,0,0,0));
    tbl.push_back(v(0,0,0,0,0,0,0,0,0,                    0,0,0,0,0,1,3,32'hAA,0,0));
    tbl.push_back(v(1,1,0,1,5,32'h100,0,0,0,              1,0,0,0,0,0,3,32'hAA,0,0));
    tbl.push_back(v(0,0,0,0,0,0,0,0,0,                    1,1,0,32'h100,0,0,3,32'hAA,0,0));
    tbl.push_back(v(0,0,0,0,0,0,0,0,0,                    1,1,0,32'h100,0,0,3,32'hAA,0,0));
    tbl.push_back(v(0,0,0,0,0,0,0,1,32'hDEADBEEF,         0,1,0,32'h100,0,0,3,32'hAA,0,0));
    tbl.push_back(v(0,0,0,0,0,0,0,0,0,                    0,0,0,32'h100,0,1,5,32'hDEADBEEF,1,0));
    tbl.push_back(v(1,0,1,0,7,32'h200,32'h1234,0,0,       1,0,0,32'h100,0,0,5,32'hDEADBEEF,1,0));
    tbl.push_back(v(0,0,0,0,0,0,0,0,0,                    1,1,1,32'h200,32'h1234,0,5,32'hDEADBEEF,1,0));
    tbl.push_back(v(0,0,0,0,0,0,0,1,32'hFFFF,             0,1,1,32'h200,32'h1234,0,5,32'hDEADBEEF,1,0));
    tbl.push_back(v(0,0,0,0,0,0,0,0,0,                    0,0,0,32'h200,32'h1234,0,5,32'hDEADBEEF,1,0));
    tbl.push_back(v(1,1,0,1,0,32'h300,0,0,0,              1,0,0,32'h200,32'h1234,0,5,32'hDEADBEEF,1,0));
    tbl.push_back(v(0,0,0,0,0,0,0,1,32'h55,               0,1,0,32'h300,0,0,5,32'hDEADBEEF,1,0));
    tbl.push_back(v(0,0,0,0,0,0,0,0,0,                    0,0,0,32'h300,0,0,0,32'h55,1,0));
    tbl.push_back(v(0,0,0,0,0,0,0,1,32'h66,               0,0,0,32'h300,0,0,0,32'h55,1,0));
    tbl.push_back(v(1,0,0,1,9,32'h77,0,1,32'h88,          0,0,0,32'h300,0,0,0,32'h55,1,0));
    tbl.push_back(v(0,0,0,0,0,0,0,0,0,                    0,0,0,32'h300,0,1,9,32'h77,0,0));
    tbl.push_back(v(1,0,0,0,4,32'h99,0,0,0,               0,0,0,32'h300,0,0,9,32'h77,0,0));
    tbl.push_back(v(0,0,0,0,0,0,0,0,0,                    0,0,0,32'h300,0,0,9,32'h77,0,0));

    // reset state, checked while reset is still asserted
    #1;
    check("rst_req", mem_req, 0);
    check("rst_stall", stall, 0);
    check("rst_wben", wb_en, 0);
    check("rst_buserr", bus_err, 0);
    do_reset();

    foreach (tbl[i]) begin
      cyc(tbl[i].iv, tbl[i].r, tbl[i].w, tbl[i].rw, tbl[i].rdi, tbl[i].alu, tbl[i].sd,
          tbl[i].ack, tbl[i].rdat);
      check($sformatf("v%0d_stall", i), stall, tbl[i].st);
      check($sformatf("v%0d_req", i), mem_req, tbl[i].rq);
      check($sformatf("v%0d_we", i), mem_we, tbl[i].we);
      check($sformatf("v%0d_addr", i), mem_addr, tbl[i].a);
      check($sformatf("v%0d_wdata", i), mem_wdata, tbl[i].wd);
      check($sformatf("v%0d_wben", i), wb_en, tbl[i].wbe);
      check($sformatf("v%0d_wbrd", i), wb_rd, tbl[i].wbr);
      check($sformatf("v%0d_wbdata", i), wb_data, tbl[i].wbd);
      check($sformatf("v%0d_m2reg", i), m2reg, tbl[i].m2);
      check($sformatf("v%0d_buserr", i), bus_err, tbl[i].er);
    end

    // timeout: four WAIT cycles without ack, then sticky error
    do_reset();
    cyc(1, 1, 0, 1, 6, 32'h400, 0, 0, 0);
    check("to_issue_stall", stall, 1);
    for (int k = 0; k < TO; k++) begin
      idle(0);
      check($sformatf("to_req%0d", k), mem_req, 1);
      check($sformatf("to_err%0d", k), bus_err, 0);
    end
    idle(0);
    check("to_req_drop", mem_req, 0);
    check("to_err", bus_err, 1);
    check("to_stall", stall, 1);
    check("to_wben", wb_en, 0);
    idle(1);
    check("to_ack_ign_err", bus_err, 1);
    check("to_ack_ign_stall", stall, 1);
    cyc(1, 0, 0, 1, 3, 32'h11, 0, 0, 0);
    idle(0);
    check("to_err_nowb", wb_en, 0);
    check("to_err_sticky", bus_err, 1);

    // ack in the last allowed cycle wins over the timeout
    do_reset();
    cyc(1, 1, 0, 1, 8, 32'h500, 0, 0, 0);
    for (int k = 0; k < TO - 1; k++) idle(0);
    cyc(0, 0, 0, 0, 0, 0, 0, 1, 32'hCAFE);
    check("win_stall", stall, 0);
    check("win_req", mem_req, 1);
    idle(0);
    check("win_err", bus_err, 0);
    check("win_wben", wb_en, 1);
    check("win_wbdata", wb_data, 32'hCAFE);
    check("win_m2reg", m2reg, 1);

    // read and write together is illegal
    do_reset();
    cyc(1, 1, 1, 1, 2, 32'h44, 32'h55, 0, 0);
    check("ill_stall", stall, 1);
    idle(0);
    check("ill_err", bus_err, 1);
    check("ill_req", mem_req, 0);
    check("ill_wben", wb_en, 0);

    // asynchronous reset in the middle of WAIT, then a clean load
    do_reset();
    cyc(1, 0, 1, 1, 10, 32'h600, 32'h77, 0, 0);
    idle(0);
    check("ar_req_before", mem_req, 1);
    check("ar_we_before", mem_we, 1);
    #2;
    rst_n = 1'b0;
    #1;
    check("ar_req", mem_req, 0);
    check("ar_we", mem_we, 0);
    check("ar_addr", mem_addr, 0);
    check("ar_wdata", mem_wdata, 0);
    check("ar_stall", stall, 0);
    check("ar_wben", wb_en, 0);
    check("ar_wbdata", wb_data, 0);
    @(negedge clk);
    rst_n = 1'b1;
    idle(1);
    check("ar_after_req", mem_req, 0);
    idle(0);
    check("ar_after_wben", wb_en, 0);
    cyc(1, 1, 0, 1, 11, 32'h700, 0, 0, 0);
    cyc(0, 0, 0, 0, 0, 0, 0, 1, 32'h1111);
    check("ar_ld_addr", mem_addr, 32'h700);
    idle(0);
    check("ar_ld_wben", wb_en, 1);
    check("ar_ld_wbrd", wb_rd, 11);
    check("ar_ld_wbdata", wb_data, 32'h1111);
    check("ar_ld_m2reg", m2reg, 1);

    // randomized traffic against the model
    do_reset();
    model_reset();
    err_age = 0;
    for (int n = 0; n < 3000; n++) begin
      logic iv, r, w;
      int kind;
      @(negedge clk);
      iv = ($urandom_range(0, 9) < 6);
      kind = $urandom_range(0, 99);
      r = (kind < 35) || (kind >= 97);
      w = (kind >= 35 && kind < 60) || (kind >= 97);
      drive(iv, r, w, $urandom_range(0, 3) != 0, 5'($urandom_range(0, 31)), $urandom,
            $urandom, $urandom_range(0, 99) < 45, $urandom);
      #1;
      model_check();
      model_clock();
      if (m_err) err_age++;
      if (err_age > 3 || $urandom_range(0, 299) == 0) begin
        do_reset();
        model_reset();
        err_age = 0;
      end
    end

    $display("Result: errors=%0d of %0d checks", nerr, nchk);
    $finish;
  end

endmodule

// File: doc/load_wb_ctrl.md
# load_wb_ctrl

Sequencing controller for the data-memory/writeback path of the CPU. It turns decoded load/store instructions into a req/ack transaction on a variable-latency data memory and stalls the core while the access is outstanding. It then drives the writeback-source select (`m2reg`), the writeback register index, the data and the write enable into the register file. It replaces the purely combinational reg/mem selection with a registered writeback stage, which lets data memory take more than one cycle.

## Interface
Parameters:
- `TIMEOUT`, default 16: maximum number of WAIT cycles without `mem_ack` before the controller declares a bus error. Legal range 1..255.
- `CNT_W`, default 8: width of the timeout counter.

Ports:
- `clk`  in  1  system clock, rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `instr_valid`  in  1  decoded instruction present this cycle.
- `mem_read`  in  1  instruction is a load.
- `mem_write`  in  1  instruction is a store.
- `reg_write`  in  1  instruction writes the register file.
- `rd`  in  5  destination register.
- `alu_data`  in  32  ALU result; also serves as the memory address.
- `store_data`  in  32  store operand.
- `mem_req`  out  1  memory request, held until ack.
- `mem_we`  out  1  1 = write, valid with `mem_req`.
- `mem_addr`  out  32  latched address.
- `mem_wdata`  out  32  latched store data.
- `mem_rdata`  in  32  read data, valid when `mem_ack`.
- `mem_ack`  in  1  one-cycle completion pulse.
- `stall`  out  1  freeze PC and decode.
- `wb_en`  out  1  register-file write enable.
- `wb_rd`  out  5  writeback register index.
- `wb_data`  out  32  writeback data.
- `m2reg`  out  1  1 = `wb_data` came from memory.
- `bus_err`  out  1  sticky error flag.

## Operation
- States: IDLE, WAIT, ERR. State is encoded in 2 bits.
- IDLE, when `instr_valid` is high:
  - `mem_read` and `mem_write` both high: this is illegal. Go to ERR.
  - `mem_read` or `mem_write` high: latch `alu_data`, `store_data`, `rd`, the load flag and `reg_write`. Set `mem_req`=1 and `mem_we`=`mem_write`. Go to WAIT.
  - Otherwise, if `reg_write` is high: the next cycle drives `wb_en`=1, `wb_rd`=`rd`, `wb_data`=`alu_data` and `m2reg`=0. No stall.
- WAIT:
  - Increment the counter each cycle that `mem_ack` is low.
  - On `mem_ack`: drop `mem_req` and return to IDLE. For a load with `reg_write` set, the next cycle drives `wb_en`=1, `wb_data`=`mem_rdata` as captured in the ack cycle, and `m2reg`=1. A store produces no writeback.
  - If the counter reaches `TIMEOUT` with no ack: drop `mem_req`, go to ERR, and issue no writeback.
- ERR: terminal until reset. `bus_err`=1, `stall`=1, `mem_req`=0, `wb_en`=0.
- `wb_en` is forced to 0 whenever the target register is 0. `wb_rd` and `wb_data` still update.
- `stall` is combinational:
  - IDLE: `instr_valid & (mem_read | mem_write)`.
  - WAIT: `!mem_ack`.
  - ERR: 1.
- `mem_ack` is ignored outside WAIT.

## Timing
- Reset values: state IDLE, counter 0. All outputs are 0: `mem_req`, `mem_we`, `mem_addr`, `mem_wdata`, `stall` (given idle inputs), `wb_en`, `wb_rd`, `wb_data`, `m2reg`, `bus_err`.
- ALU writeback latency: 1 cycle. An instruction in cycle T produces `wb_en` in T+1. `wb_en` is a one-cycle pulse per instruction.
- Load sequence with decode in T0: `mem_req` is high from T1. If ack arrives at Tk (k≥1), `stall` is low in Tk and `wb_en`/`m2reg` are high in Tk+1. Minimum load latency is 2 cycles.
- `mem_addr`, `mem_wdata` and `mem_we` are stable for the whole time `mem_req` is high.
- Timeout: ERR is entered the cycle after the `TIMEOUT`-th consecutive WAIT cycle without ack. An ack arriving in that same cycle wins.
- Reset asserted mid-WAIT: `mem_req` drops immediately (asynchronous) and no writeback is issued.

## Structure
- Shared package `cpu_pkg`: the state enum (IDLE/WAIT/ERR) and `REG_ZERO`=5'd0.
- Single module, no sub-modules. The timeout counter is inline.

## Test plan
- Reset, then an ALU instruction with `rd`=3 and `alu_data`=0x0000_00AA: `wb_en`=1, `wb_rd`=3, `wb_data`=0xAA, `m2reg`=0 one cycle later, and `stall` never asserts.
- Load with `rd`=5, address 0x100, ack after 3 cycles carrying `mem_rdata`=0xDEAD_BEEF: `stall` is high for 3 cycles, then `wb_en`=1, `wb_data`=0xDEADBEEF, `m2reg`=1.
- Store to 0x200 of data 0x1234: `mem_we`=1, `mem_addr`=0x200, `mem_wdata`=0x1234 held until ack, and `wb_en` stays 0.
- Load to `rd`=0 with ack after 1 cycle: `wb_en` stays 0 and `m2reg`=1.
- `TIMEOUT`=4 with no ack: `mem_req` high for 4 cycles, then `bus_err`=1 and `stall`=1 permanently. A later `mem_ack` is ignored.
- `rst_n` low during WAIT: all outputs are 0 immediately. A new load issued after reset completes normally.
